// File: rtl/x_multdiv_seq_if.sv
`default_nettype none
// ============================================================================
//  Module   : x_multdiv_seq_if
//  Purpose  : Bundles the D/X latch outputs that feed the execute-stage
//             multiply/divide sequencer with the status and result signals it
//             returns to the pipeline.
//  Signals  : X_IR         - instruction held in the D/X latch
//             X_A, X_B     - rs / rt operand values from the D/X latch
//             md_stall     - freeze PC, F/D, D/X and bubble X/M
//             md_busy      - iterating
//             md_ready     - one-cycle result-valid pulse
//             md_result    - signed product / quotient (low WIDTH bits)
//             md_exception - mul overflow or div-by-zero, valid with md_ready
//  Modports : master - pipeline side, slave - sequencer side
//  Revision : 1.0 - initial release
// ============================================================================
interface x_multdiv_seq_if #(
  parameter int WIDTH = 32
);
  logic [31:0]      X_IR;
  logic [WIDTH-1:0] X_A;
  logic [WIDTH-1:0] X_B;
  logic             md_stall;
  logic             md_busy;
  logic             md_ready;
  logic [WIDTH-1:0] md_result;
  logic             md_exception;

  modport master (
    output X_IR, X_A, X_B,
    input  md_stall, md_busy, md_ready, md_result, md_exception
  );

  modport slave (
    input  X_IR, X_A, X_B,
    output md_stall, md_busy, md_ready, md_result, md_exception
  );
endinterface
`default_nettype wire

// File: rtl/x_multdiv_seq.sv
`default_nettype none
// ============================================================================
//  Module   : x_multdiv_seq
//  Purpose  : Execute-stage multi-cycle multiply/divide sequencer. Decodes an
//             R-type mul/div directly from the D/X latch, captures operand
//             magnitudes, runs WIDTH shift-add (mul) or restoring
//             shift-subtract (div) iterations, then presents the signed
//             result for one release cycle while stalling the front end.
//  Ports    : clock - pipeline clock, rising edge
//             reset - asynchronous, active-high
//             bus   - x_multdiv_seq_if.slave (X_IR/X_A/X_B in, md_* out)
//  Options  : MULTDIV_EARLY_EXIT_EN - when defined, a mul leaves RUN as soon
//             as the remaining multiplier magnitude is zero (min 1 RUN cycle).
//  Revision : 1.0 - initial release
// ============================================================================
module x_multdiv_seq #(
  parameter int         WIDTH     = 32,
  parameter logic [4:0] MUL_ALUOP = 5'b00110,
  parameter logic [4:0] DIV_ALUOP = 5'b00111
) (
  input  logic             clock,
  input  logic             reset,
  x_multdiv_seq_if.slave   bus
);

  localparam int             CW        = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  LAST_ITER = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]         state;
  logic [1:0]         next_state;

  // Decode
  logic               is_md;
  logic               is_div;
  logic               div_by_zero;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic               unused_ir;

  // Captured operation context
  logic               op_div;
  logic               sign;
  logic [CW-1:0]      counter;
  // shreg: mul multiplier (shifts right) / div dividend becoming quotient (shifts left)
  logic [WIDTH-1:0]   shreg;
  // opnd : mul multiplicand (shifts left) / div divisor in the low WIDTH bits
  logic [2*WIDTH-1:0] opnd;
  // acc  : mul partial product / div partial remainder in the low WIDTH bits
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   result_q;
  logic               exc_q;

  // One-iteration datapath
  logic [2*WIDTH-1:0] mul_sum;
  logic [WIDTH-1:0]   mplier_next;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     diff;
  logic               q_bit;
  logic [WIDTH-1:0]   rem_next;
  logic [WIDTH-1:0]   quo_next;
  logic [2*WIDTH-1:0] prod_signed;
  logic [WIDTH-1:0]   quo_signed;
  logic               mul_ovf;
  logic               div_ovf;
  logic               last_iter;
  logic               early_exit;
  logic               leave_run;

  // --------------------------------------------------------------------------
  // Decode straight off the D/X latch
  // --------------------------------------------------------------------------
  assign is_md       = (bus.X_IR[31:27] == 5'b00000) &&
                       ((bus.X_IR[6:2] == MUL_ALUOP) || (bus.X_IR[6:2] == DIV_ALUOP));
  assign is_div      = (bus.X_IR[6:2] == DIV_ALUOP);
  assign div_by_zero = is_div && (bus.X_B == '0);
  assign mag_a       = bus.X_A[WIDTH-1] ? -bus.X_A : bus.X_A;
  assign mag_b       = bus.X_B[WIDTH-1] ? -bus.X_B : bus.X_B;
  assign unused_ir   = ^{bus.X_IR[26:7], bus.X_IR[1:0]};

  // --------------------------------------------------------------------------
  // Iteration datapath and final signed result
  // --------------------------------------------------------------------------
  always_comb begin
    mul_sum     = acc + (shreg[0] ? opnd : '0);
    mplier_next = shreg >> 1;

    // Restoring step: bring in the next dividend bit and trial-subtract.
    // The partial remainder is always below the divisor, so a set bit WIDTH
    // of the (WIDTH+1)-bit difference means the trial went negative.
    rem_sh      = {acc[WIDTH-1:0], shreg[WIDTH-1]};
    diff        = rem_sh - {1'b0, opnd[WIDTH-1:0]};
    q_bit       = ~diff[WIDTH];
    rem_next    = q_bit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    quo_next    = {shreg[WIDTH-2:0], q_bit};

    prod_signed = sign ? -mul_sum : mul_sum;
    // Fits in WIDTH signed bits only if the top WIDTH+1 bits are a pure sign extension
    mul_ovf     = !((&prod_signed[2*WIDTH-1:WIDTH-1]) || !(|prod_signed[2*WIDTH-1:WIDTH-1]));
    quo_signed  = sign ? -quo_next : quo_next;
    // A positive quotient with the top bit set is +2^(WIDTH-1): only MIN / -1
    div_ovf     = ~sign & quo_next[WIDTH-1];
  end

  assign last_iter = (counter == LAST_ITER);

`ifdef MULTDIV_EARLY_EXIT_EN
  assign early_exit = ~op_div & (mplier_next == '0);
`else
  assign early_exit = 1'b0;
`endif

  assign leave_run = last_iter | early_exit;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (is_md) begin
          next_state = div_by_zero ? DONE : RUN;
        end
      end
      RUN: begin
        if (leave_run) begin
          next_state = DONE;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    bus.md_busy  = (state == RUN);
    bus.md_ready = (state == DONE);
    // Combinational so the mul/div is held from its very first X cycle;
    // masked during reset so every output reads 0 while reset is asserted.
    bus.md_stall = is_md && (state != DONE) && !reset;
  end

  assign bus.md_result    = result_q;
  assign bus.md_exception = exc_q;

  // --------------------------------------------------------------------------
  // Operand capture, iteration and result registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op_div   <= 1'b0;
      sign     <= 1'b0;
      counter  <= '0;
      shreg    <= '0;
      opnd     <= '0;
      acc      <= '0;
      result_q <= '0;
      exc_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (is_md) begin
            op_div  <= is_div;
            sign    <= bus.X_A[WIDTH-1] ^ bus.X_B[WIDTH-1];
            counter <= '0;
            acc     <= '0;
            opnd    <= {{WIDTH{1'b0}}, (is_div ? mag_b : mag_a)};
            shreg   <= is_div ? mag_a : mag_b;
            if (div_by_zero) begin
              result_q <= '0;
              exc_q    <= 1'b1;
            end
          end
        end
        RUN: begin
          counter <= counter + 1'b1;
          if (op_div) begin
            acc   <= {{WIDTH{1'b0}}, rem_next};
            shreg <= quo_next;
          end else begin
            acc   <= mul_sum;
            opnd  <= opnd << 1;
            shreg <= mplier_next;
          end
          if (leave_run) begin
            result_q <= op_div ? quo_signed : prod_signed[WIDTH-1:0];
            exc_q    <= op_div ? div_ovf : mul_ovf;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_x_multdiv_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_x_multdiv_seq
//  Purpose  : Self-checking bench for x_multdiv_seq. Directed corner cases
//             followed by random mul/div traffic, each result compared with
//             a signed-arithmetic reference model. Honours
//             MULTDIV_EARLY_EXIT_EN for expected latency.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_x_multdiv_seq;

  localparam int         WIDTH  = 32;
  localparam logic [4:0] MUL_OP = 5'b00110;
  localparam logic [4:0] DIV_OP = 5'b00111;
  localparam logic [4:0] ADD_OP = 5'b00000;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   compared   = 0;
  int   mismatched = 0;
  int   cyc        = 0;

  x_multdiv_seq_if #(.WIDTH(WIDTH)) bus ();

  x_multdiv_seq #(.WIDTH(WIDTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: signed 64-bit arithmetic; occupancy in X cycles.
  function automatic void model(input logic is_div, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] res, output logic exc, output int occ);
    longint pa, pb, p, q, mag;
    int     nbits;
    pa = longint'(signed'(a));
    pb = longint'(signed'(b));
    if (!is_div) begin
      p   = pa * pb;
      res = p[31:0];
      exc = (p > 64'sd2147483647) || (p < -64'sd2147483648);
      occ = 34;
`ifdef MULTDIV_EARLY_EXIT_EN
      mag   = (pb < 0) ? -pb : pb;
      nbits = 0;
      while (mag != 0) begin
        nbits++;
        mag = mag / 2;
      end
      occ = ((nbits < 1) ? 1 : nbits) + 2;
`endif
    end else if (pb == 0) begin
      res = 32'h0;
      exc = 1'b1;
      occ = 2;
    end else begin
      q   = pa / pb;
      res = q[31:0];
      exc = (q > 64'sd2147483647);
      occ = 34;
    end
  endfunction

  // Put a mul/div into X after the next rising edge and follow it to md_ready.
  task automatic run_op(input string tag, input logic is_div, input logic [31:0] a,
                        input logic [31:0] b, output int ready_cyc, output int occ,
                        output logic [31:0] er, output logic ee);
    int k;
    int stall_hi;
    bit got;
    model(is_div, a, b, er, ee, occ);
    @(posedge clock); #1;
    bus.X_IR = {5'b00000, 20'($urandom), (is_div ? DIV_OP : MUL_OP), 2'($urandom)};
    bus.X_A  = a;
    bus.X_B  = b;
    got = 0; k = 0; stall_hi = 0; ready_cyc = -1;
    while (!got && k < 100) begin
      @(negedge clock);
      if (bus.md_ready) begin
        got = 1;
        ready_cyc = cyc;
        check({tag, " ready cycle"}, 64'(k), 64'(occ - 1));
        check({tag, " stall in DONE"}, 64'(bus.md_stall), 64'd0);
        check({tag, " result"}, 64'(bus.md_result), 64'(er));
        check({tag, " exception"}, 64'(bus.md_exception), 64'(ee));
      end else begin
        if (bus.md_stall) stall_hi++;
        k++;
      end
    end
    if (!got) check({tag, " timeout"}, 64'd0, 64'd1);
    else      check({tag, " stall cycles"}, 64'(stall_hi), 64'(occ - 1));
  endtask

  // Advance D/X to a non-mul/div and confirm no stall and held outputs.
  task automatic drive_add(input string tag, input logic [31:0] held_res, input logic held_exc);
    @(posedge clock); #1;
    bus.X_IR = {5'b00000, 20'($urandom), ADD_OP, 2'b00};
    bus.X_A  = $urandom;
    bus.X_B  = $urandom;
    @(negedge clock);
    check({tag, " add stall"}, 64'(bus.md_stall), 64'd0);
    check({tag, " add ready"}, 64'(bus.md_ready), 64'd0);
    check({tag, " add busy"}, 64'(bus.md_busy), 64'd0);
    check({tag, " held result"}, 64'(bus.md_result), 64'(held_res));
    check({tag, " held exc"}, 64'(bus.md_exception), 64'(held_exc));
  endtask

  initial begin
    int          r1, r2, occ1, occ2, seen_ready;
    logic [31:0] er, a, b;
    logic        ee, dv;

    bus.X_IR = 32'h0;
    bus.X_A  = 32'h0;
    bus.X_B  = 32'h0;

    // Reset state
    repeat (2) @(negedge clock);
    check("reset ready", 64'(bus.md_ready), 64'd0);
    check("reset busy", 64'(bus.md_busy), 64'd0);
    check("reset result", 64'(bus.md_result), 64'd0);
    check("reset exc", 64'(bus.md_exception), 64'd0);
    check("reset stall", 64'(bus.md_stall), 64'd0);
    reset = 1'b0;

    // Directed cases
    run_op("mul 7*-3", 1'b0, 32'd7, -32'sd3, r1, occ1, er, ee);
    drive_add("mul 7*-3", er, ee);
    run_op("div 100/-7", 1'b1, 32'd100, -32'sd7, r1, occ1, er, ee);
    drive_add("div 100/-7", er, ee);
    run_op("div 5/0", 1'b1, 32'd5, 32'd0, r1, occ1, er, ee);
    drive_add("div 5/0", er, ee);
    run_op("mul 2^16*2^16", 1'b0, 32'h0001_0000, 32'h0001_0000, r1, occ1, er, ee);
    run_op("mul min*1", 1'b0, 32'h8000_0000, 32'd1, r1, occ1, er, ee);
    run_op("div min/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, r1, occ1, er, ee);
    run_op("mul 5*1", 1'b0, 32'd5, 32'd1, r1, occ1, er, ee);

    // Back-to-back
    run_op("b2b 6*7", 1'b0, 32'd6, 32'd7, r1, occ1, er, ee);
    run_op("b2b 2*-2", 1'b0, 32'd2, -32'sd2, r2, occ2, er, ee);
    check("b2b ready spacing", 64'(r2 - r1), 64'(occ2));
    drive_add("b2b", er, ee);

    // Non-zero opcode with a mul ALU field is not a mul
    @(posedge clock); #1;
    bus.X_IR = {5'b00001, 20'h0, MUL_OP, 2'b00};
    @(negedge clock);
    check("non-R stall", 64'(bus.md_stall), 64'd0);
    @(negedge clock);
    check("non-R busy", 64'(bus.md_busy), 64'd0);

    // Reset in the middle of RUN (counter 10 at X cycle 11)
    @(posedge clock); #1;
    bus.X_IR = {5'b00000, 20'h0, MUL_OP, 2'b00};
    bus.X_A  = 32'd3;
    bus.X_B  = 32'h4000_0001;
    repeat (12) @(negedge clock);
    check("pre-reset busy", 64'(bus.md_busy), 64'd1);
    reset = 1'b1;
    #1;
    check("async reset busy", 64'(bus.md_busy), 64'd0);
    check("async reset result", 64'(bus.md_result), 64'd0);
    check("async reset exc", 64'(bus.md_exception), 64'd0);
    check("async reset stall", 64'(bus.md_stall), 64'd0);
    bus.X_IR = {5'b00000, 20'h0, ADD_OP, 2'b00};
    seen_ready = 0;
    repeat (3) begin
      @(negedge clock);
      if (bus.md_ready) seen_ready++;
    end
    check("reset no ready", 64'(seen_ready), 64'd0);
    reset = 1'b0;
    run_op("mul 3*3 after reset", 1'b0, 32'd3, 32'd3, r1, occ1, er, ee);
    drive_add("after reset", er, ee);

    // Random traffic
    for (int i = 0; i < 24; i++) begin
      dv = 1'($urandom);
      case ($urandom % 6)
        0:       a = 32'h8000_0000;
        1:       a = 32'hFFFF_FFFF;
        2:       a = 32'($urandom_range(0, 1000));
        default: a = $urandom;
      endcase
      case ($urandom % 6)
        0:       b = 32'h0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = 32'($urandom_range(0, 40)) - 32'd20;
        default: b = $urandom;
      endcase
      run_op($sformatf("rand%0d %s", i, dv ? "div" : "mul"), dv, a, b, r1, occ1, er, ee);
      if ($urandom % 2) drive_add($sformatf("rand%0d", i), er, ee);
    end

    drive_add("final", er, ee);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
